// File: rtl/spi_master_seq.sv
// Command sequencer that serialises 10-bit {cmd_type, payload} words into SPI
// frames for the slave/RAM subsystem and returns read-data bytes captured from MISO.
`timescale 1ns/1ps
module spi_master_seq #(
  parameter int ADDR_SIZE  = 8,
  parameter int RD_LATENCY = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_type,
  input  logic [ADDR_SIZE-1:0] cmd_data,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO,
  output logic                 rsp_valid,
  output logic [ADDR_SIZE-1:0] rsp_data,
  output logic                 busy,
  output logic                 seq_err
);

  localparam int SW   = ADDR_SIZE + 2;
  localparam int CW   = $clog2(SW + 16);

  typedef enum logic [2:0] {
    M_IDLE, M_START, M_CMD, M_SHIFT, M_WAIT, M_CAPTURE, M_END
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         shift_q, shift_d;
  logic [ADDR_SIZE-1:0]  cap_q, cap_d;
  logic [ADDR_SIZE-1:0]  rsp_data_q, rsp_data_d;
  logic                  is_rd_q, is_rd_d;
  logic                  rd_addr_seen_q, rd_addr_seen_d;
  logic                  ss_n_q, ss_n_d;
  logic                  mosi_q, mosi_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  seq_err_q, seq_err_d;
  logic                  accept;

  assign accept    = cmd_valid & ready_q;
  assign cmd_ready = ready_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign seq_err   = seq_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= M_IDLE;
      cnt_q          <= '0;
      shift_q        <= '0;
      cap_q          <= '0;
      rsp_data_q     <= '0;
      is_rd_q        <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      ss_n_q         <= 1'b1;
      mosi_q         <= 1'b0;
      ready_q        <= 1'b0;
      busy_q         <= 1'b0;
      rsp_valid_q    <= 1'b0;
      seq_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      cap_q          <= cap_d;
      rsp_data_q     <= rsp_data_d;
      is_rd_q        <= is_rd_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      ss_n_q         <= ss_n_d;
      mosi_q         <= mosi_d;
      ready_q        <= ready_d;
      busy_q         <= busy_d;
      rsp_valid_q    <= rsp_valid_d;
      seq_err_q      <= seq_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      M_IDLE:  if (accept) state_d = M_START;
      M_START: state_d = M_CMD;
      M_CMD: begin
        state_d = M_SHIFT;
        cnt_d   = CW'(SW - 1);
      end
      M_SHIFT: begin
        if (cnt_q == '0) begin
          state_d = is_rd_q ? M_WAIT : M_END;
          cnt_d   = is_rd_q ? CW'(RD_LATENCY - 1) : CW'(GAP_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      M_WAIT: begin
        if (cnt_q == '0) begin
          state_d = M_CAPTURE;
          cnt_d   = CW'(ADDR_SIZE - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      M_CAPTURE: begin
        if (cnt_q == '0) begin
          state_d = M_END;
          cnt_d   = CW'(GAP_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      M_END: begin
        if (cnt_q == '0) state_d = M_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = M_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    shift_d        = shift_q;
    cap_d          = cap_q;
    rsp_data_d     = rsp_data_q;
    is_rd_d        = is_rd_q;
    rd_addr_seen_d = rd_addr_seen_q;
    rsp_valid_d    = 1'b0;
    seq_err_d      = 1'b0;
    mosi_d         = 1'b0;
    ss_n_d         = (state_d == M_IDLE) || (state_d == M_END);
    ready_d        = (state_d == M_IDLE);
    busy_d         = (state_d != M_IDLE);

    if (accept) begin
      shift_d   = {cmd_type, cmd_data};
      is_rd_d   = (cmd_type == 2'b11);
      seq_err_d = (cmd_type == 2'b11) && !rd_addr_seen_q;
      if (cmd_type == 2'b10)      rd_addr_seen_d = 1'b1;
      else if (cmd_type == 2'b11) rd_addr_seen_d = 1'b0;
    end

    unique case (state_d)
      M_START: mosi_d = cmd_type[1];
      M_CMD:   mosi_d = shift_q[SW-1];
      M_SHIFT: begin
        mosi_d  = shift_q[SW-1];
        shift_d = shift_q << 1;
      end
      default: mosi_d = 1'b0;
    endcase

    if (state_q == M_CAPTURE) begin
      cap_d = {cap_q[ADDR_SIZE-2:0], MISO};
      if (state_d == M_END) begin
        rsp_data_d  = cap_d;
        rsp_valid_d = 1'b1;
      end
    end
  end

endmodule
